// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply / restoring divide,
// one sign-fix cycle, one-cycle DONE pulse. Divide-by-zero and signed overflow bypass CALC.
module otter_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam logic [2:0] FnMul    = 3'd0;
  localparam logic [2:0] FnMulh   = 3'd1;
  localparam logic [2:0] FnMulhsu = 3'd2;
  localparam logic [2:0] FnMulhu  = 3'd3;
  localparam logic [2:0] FnDiv    = 3'd4;
  localparam logic [2:0] FnDivu   = 3'd5;
  localparam logic [2:0] FnRem    = 3'd6;
  localparam logic [2:0] FnRemu   = 3'd7;

  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         funct_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opa_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  logic               a_sgn, b_sgn, neg_d;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   lo_fix, hi_fix;
  logic [WIDTH-1:0]   fix_res;

  // Operand preparation from the live inputs, used only on the accepting edge.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (FUNCT3)
      FnMulh, FnDiv, FnRem: begin
        a_sgn = A[WIDTH-1];
        b_sgn = B[WIDTH-1];
      end
      FnMulhsu: a_sgn = A[WIDTH-1];
      default: ;
    endcase
    a_mag    = a_sgn ? -A : A;
    b_mag    = b_sgn ? -B : B;
    neg_d    = (FUNCT3 == FnRem) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = FUNCT3[2] && (B == '0);
    div_ovf  = ((FUNCT3 == FnDiv) || (FUNCT3 == FnRem)) && (A == MinNeg) && (B == '1);
    if (div_zero) special_res = FUNCT3[1] ? A : '1;
    else          special_res = FUNCT3[1] ? '0 : MinNeg;
  end

  // One iteration: acc holds {accumulator, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opa_q};
    rem_sub = rem_sh[WIDTH-1:0] - opa_q;
    if (funct_q[2]) begin
      if (rem_ge) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
      else        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    lo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    hi_fix   = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (funct_q)
      FnMul:                     fix_res = prod_fix[WIDTH-1:0];
      FnMulh, FnMulhsu, FnMulhu: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      FnDiv, FnDivu:             fix_res = lo_fix;
      FnRem, FnRemu:             fix_res = hi_fix;
      default:                   fix_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (START && !FLUSH) begin
            funct_q <= FUNCT3;
            neg_q   <= neg_d;
            cnt_q   <= '0;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              acc_q   <= FUNCT3[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opa_q   <= FUNCT3[2] ? b_mag : a_mag;
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (FLUSH) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) state_q <= StFix;
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (FLUSH) begin
            state_q <= StIdle;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: doc/otter_muldiv_unit.md
Name: otter_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the OTTER pipeline. It sits in the execute stage, in parallel with the ALU. Its RESULT feeds a spare input of the 6-to-1 writeback-select mux. The hazard logic stalls the pipeline on BUSY and releases it on DONE.

Parameters:
WIDTH  32  operand/result width; only 32 is supported (counter and special-case constants sized for 32)
CNT_W  6   iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK     input   1   system clock, all state updates on rising edge
RST     input   1   synchronous reset, active-high
START   input   1   request pulse; sampled only in IDLE
FUNCT3  input   3   RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
A       input   32  rs1 operand (multiplicand / dividend)
B       input   32  rs2 operand (multiplier / divisor)
FLUSH   input   1   abort the in-flight op (branch mispredict / trap)
BUSY    output  1   high from the cycle after an accepted START until the DONE cycle, exclusive of DONE
DONE    output  1   one-cycle completion pulse
RESULT  output  32  result; valid when DONE=1; held until the next accepted START

Behaviour:
- Reset (RST=1 at an edge): state→IDLE; BUSY=0, DONE=0, RESULT=0, counter=0. This applies regardless of the current state, including mid-CALC.
- States: IDLE, CALC, FIX, DONE.
- IDLE, START=1: latch FUNCT3, A and B. Later changes on A, B or FUNCT3 have no effect.
  - Special case, divide by zero (FUNCT3≥4, B=0): go directly to DONE.
  - Special case, signed overflow (FUNCT3 = DIV or REM, A=0x80000000, B=0xFFFFFFFF): go directly to DONE.
  - Otherwise: go to CALC with counter=0.
- START while not in IDLE: ignored; no queueing.
- Sign prep at latch:
  - Signed operands are replaced by their magnitudes; the result sign is recorded.
  - MULH: both operands signed. MULHSU: A signed, B unsigned. DIV/REM: both signed.
  - MUL, MULHU, DIVU and REMU are treated as unsigned; MUL low 32 bits are sign-independent.
- CALC: exactly 32 cycles, one bit per cycle; the counter increments and the state moves to FIX when counter=31.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring division, producing a 32-bit quotient and a 32-bit remainder.
- FIX (1 cycle): apply two's-complement negation if the result sign is negative.
  - Product sign = sign(A) xor sign(B), considering signed operands only.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
  - Select: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register RESULT, then go to DONE.
- DONE (1 cycle): DONE=1, BUSY=0, then go to IDLE. A START in the DONE cycle is ignored.
- Latency, START accepted at edge N:
  - Normal op: BUSY high for cycles N+1..N+33; DONE=1 in cycle N+34.
  - Special case: DONE=1 in cycle N+1; BUSY never asserts.
- Special-case results:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - Overflow: DIV → 0x80000000; REM → 0.
- FLUSH=1 in CALC or FIX: go to IDLE next cycle; no DONE; RESULT keeps its previous value.
  - FLUSH in IDLE or DONE has no effect; the DONE pulse still occurs.
- Simultaneous events:
  - FLUSH and START in IDLE: FLUSH wins; the START is not accepted.
  - RST wins over everything.

Test Plan:
- MUL A=7, B=0xFFFFFFFD, START at N → RESULT=0xFFFFFFEB, DONE only in cycle N+34, BUSY high for exactly 33 cycles.
- MULH A=B=0x80000000 → 0x40000000. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM 0xFFFFFFF9/2 → 0xFFFFFFFF. Change A and B to random values during CALC → results unchanged.
- DIV 5/0 → 0xFFFFFFFF, and REM 5/0 → 5, each with DONE in cycle N+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 with DONE in N+1.
- FLUSH at cycle N+10 → IDLE, no DONE ever, RESULT unchanged. A new START at N+12 completes normally at N+46.
- RST at cycle N+20 → BUSY=0, DONE=0 and RESULT=0 the next cycle. A START pulsed while BUSY is ignored: exactly one DONE.
